croc_obi_addr_demux: RTL and testbench

Parametrised OBI address demultiplexer for the Croc interconnect. It takes one OBI manager port, decodes each request against a rule table supplied at runtime, and steers it to one of `NumSbr` subordinate ports or to an internal error subordinate. It tracks outstanding transactions so responses return in order. It replaces fixed per-bus decode (main crossbar rules, peripheral map) with a single reusable block that supports overlapping rules, a bounded number of outstanding requests, and an optional decode-error counter.

---
 rtl/croc_obi_addr_demux.sv | 179 +++++++++++++++++
 tb/tb_croc_obi_addr_demux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/croc_obi_addr_demux.sv
// OBI address demultiplexer: runtime rule-table decode onto NumSbr ports plus an internal error subordinate.
// Optional decode-error counter enabled by defining CROC_DEMUX_ERR_COUNT_EN.
module croc_obi_addr_demux #(
  parameter int NumRules = 4,
  parameter int NumSbr   = 4,
  parameter int IdWidth  = 1,
  parameter int MaxTrans = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumRules*96-1:0]    rules_i,
  input  logic                      mgr_req_i,
  input  logic [31:0]               mgr_addr_i,
  input  logic                      mgr_we_i,
  input  logic [3:0]                mgr_be_i,
  input  logic [31:0]               mgr_wdata_i,
  input  logic [IdWidth-1:0]        mgr_aid_i,
  output logic                      mgr_gnt_o,
  output logic                      mgr_rvalid_o,
  output logic [31:0]               mgr_rdata_o,
  output logic [IdWidth-1:0]        mgr_rid_o,
  output logic                      mgr_err_o,
  output logic [NumSbr-1:0]         sbr_req_o,
  output logic [31:0]               sbr_addr_o,
  output logic                      sbr_we_o,
  output logic [3:0]                sbr_be_o,
  output logic [31:0]               sbr_wdata_o,
  output logic [IdWidth-1:0]        sbr_aid_o,
  input  logic [NumSbr-1:0]         sbr_gnt_i,
  input  logic [NumSbr-1:0]         sbr_rvalid_i,
  input  logic [NumSbr*32-1:0]      sbr_rdata_i,
  input  logic [NumSbr*IdWidth-1:0] sbr_rid_i,
  input  logic [NumSbr-1:0]         sbr_err_i,
  output logic [15:0]               err_cnt_o
);

  localparam int TgtWidth = $clog2(NumSbr + 1);
  localparam int CntWidth = $clog2(MaxTrans + 1);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaxTrans);
  localparam logic [31:0]         ErrData = 32'hBADCAB1E;

  logic [TgtWidth-1:0] tgt_s;
  logic [TgtWidth-1:0] last_tgt_r;
  logic [CntWidth-1:0] cnt_r;
  logic                found_s;
  logic                stall_s;
  logic                hs_s;
  logic                err_hs_s;
  logic                rvalid_s;
  logic                err_rvalid_r;
  logic [IdWidth-1:0]  err_rid_r;

  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_wdata_o = mgr_wdata_i;
  assign sbr_aid_o   = mgr_aid_i;

  // Address decode: first matching rule wins; bad idx or no match goes to target 0
  always_comb begin
    tgt_s   = '0;
    found_s = 1'b0;
    for (int r = 0; r < NumRules; r++) begin
      if (!found_s && (rules_i[r*96+32 +: 32] <= mgr_addr_i) && (mgr_addr_i < rules_i[r*96 +: 32])) begin
        found_s = 1'b1;
        if ((rules_i[r*96+64 +: 32] != 32'd0) && (rules_i[r*96+64 +: 32] <= 32'(NumSbr))) begin
          tgt_s = TgtWidth'(rules_i[r*96+64 +: 32]);
        end else begin
          tgt_s = '0;
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  // Switching targets must wait for all outstanding responses so they stay ordered
  assign stall_s  = (cnt_r == CntMax) || ((cnt_r != '0) && (tgt_s != last_tgt_r));
  assign hs_s     = mgr_req_i & mgr_gnt_o;
  assign err_hs_s = hs_s && (tgt_s == '0);

  // Request steering and grant return
  always_comb begin
    mgr_gnt_o = 1'b0;
    sbr_req_o = '0;
    if (!stall_s) begin
      if (tgt_s == '0) begin
        mgr_gnt_o = 1'b1;
      end else begin
        mgr_gnt_o = 1'b0;
      end
      for (int p = 0; p < NumSbr; p++) begin
        if (tgt_s == TgtWidth'(p + 1)) begin
          sbr_req_o[p] = mgr_req_i;
          mgr_gnt_o    = sbr_gnt_i[p];
        end else begin
          sbr_req_o[p] = 1'b0;
        end
      end
    end else begin
      mgr_gnt_o = 1'b0;
    end
  end

  // Response mux from the target of the last handshake
  always_comb begin
    rvalid_s    = err_rvalid_r;
    mgr_rdata_o = ErrData;
    mgr_rid_o   = err_rid_r;
    mgr_err_o   = 1'b1;
    for (int p = 0; p < NumSbr; p++) begin
      if (last_tgt_r == TgtWidth'(p + 1)) begin
        rvalid_s    = sbr_rvalid_i[p];
        mgr_rdata_o = sbr_rdata_i[p*32 +: 32];
        mgr_rid_o   = sbr_rid_i[p*IdWidth +: IdWidth];
        mgr_err_o   = sbr_err_i[p];
      end else begin
        rvalid_s = rvalid_s;
      end
    end
  end

  // A response is only meaningful while something is outstanding
  assign mgr_rvalid_o = rvalid_s && (cnt_r != '0);

  // Outstanding counter and last target
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r      <= '0;
      last_tgt_r <= '0;
    end else begin
      case ({hs_s, mgr_rvalid_o})
        2'b10:   cnt_r <= cnt_r + CntWidth'(1);
        2'b01:   cnt_r <= cnt_r - CntWidth'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (hs_s) begin
        last_tgt_r <= tgt_s;
      end else begin
        last_tgt_r <= last_tgt_r;
      end
    end
  end

  // Error subordinate: answers every accepted request one cycle later
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_rvalid_r <= 1'b0;
      err_rid_r    <= '0;
    end else begin
      err_rvalid_r <= err_hs_s;
      if (err_hs_s) begin
        err_rid_r <= mgr_aid_i;
      end else begin
        err_rid_r <= err_rid_r;
      end
    end
  end

`ifdef CROC_DEMUX_ERR_COUNT_EN
  logic [15:0] err_cnt_r;

  // Saturating decode-error counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_r <= 16'h0000;
    end else if (err_hs_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'h0001;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt_o = err_cnt_r;
`else
  assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_croc_obi_addr_demux.sv
// Directed bench for croc_obi_addr_demux: decode, error subordinate, stall and reset behaviour.
module tb_croc_obi_addr_demux;

`ifdef CROC_DEMUX_ERR_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [383:0] rules_i;
  logic         mgr_req_i;
  logic [31:0]  mgr_addr_i;
  logic         mgr_we_i;
  logic [3:0]   mgr_be_i;
  logic [31:0]  mgr_wdata_i;
  logic [0:0]   mgr_aid_i;
  logic         mgr_gnt_o;
  logic         mgr_rvalid_o;
  logic [31:0]  mgr_rdata_o;
  logic [0:0]   mgr_rid_o;
  logic         mgr_err_o;
  logic [3:0]   sbr_req_o;
  logic [31:0]  sbr_addr_o;
  logic         sbr_we_o;
  logic [3:0]   sbr_be_o;
  logic [31:0]  sbr_wdata_o;
  logic [0:0]   sbr_aid_o;
  logic [3:0]   sbr_gnt_i;
  logic [3:0]   sbr_rvalid_i;
  logic [127:0] sbr_rdata_i;
  logic [3:0]   sbr_rid_i;
  logic [3:0]   sbr_err_i;
  logic [15:0]  err_cnt_o;

  int checks = 0;
  int errors = 0;

  croc_obi_addr_demux dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rules_i(rules_i),
    .mgr_req_i(mgr_req_i), .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
    .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i), .mgr_aid_i(mgr_aid_i),
    .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o),
    .mgr_rid_o(mgr_rid_o), .mgr_err_o(mgr_err_o),
    .sbr_req_o(sbr_req_o), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
    .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o), .sbr_aid_o(sbr_aid_o),
    .sbr_gnt_i(sbr_gnt_i), .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i),
    .sbr_rid_i(sbr_rid_i), .sbr_err_i(sbr_err_i), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] rule(input logic [31:0] idx, input logic [31:0] s, input logic [31:0] e);
    return {idx, s, e};
  endfunction

  task automatic req(input logic [31:0] addr, input logic aid);
    mgr_req_i  = 1'b1;
    mgr_addr_i = addr;
    mgr_aid_i  = aid;
  endtask

  logic [383:0] rules_a;
  logic [383:0] rules_b;

  initial begin
    rules_a = {rule(32'd3, 32'h6000, 32'h6000), rule(32'd5, 32'h3000, 32'h4000),
               rule(32'd2, 32'h1000, 32'h2000), rule(32'd1, 32'h0000, 32'h1000)};
    rules_b = {rule(32'd0, 32'h0, 32'h0), rule(32'd0, 32'h0, 32'h0),
               rule(32'd1, 32'h0000, 32'h1000), rule(32'd2, 32'h0000, 32'h0100)};
    rules_i      = rules_a;
    rst_ni       = 1'b0;
    mgr_req_i    = 1'b0;
    mgr_addr_i   = 32'h0;
    mgr_we_i     = 1'b0;
    mgr_be_i     = 4'hF;
    mgr_wdata_i  = 32'h12345678;
    mgr_aid_i    = 1'b0;
    sbr_gnt_i    = 4'b1111;
    sbr_rvalid_i = 4'b0000;
    sbr_rdata_i  = {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hCAFE0002, 32'hCAFE0001};
    sbr_rid_i    = 4'b0000;
    sbr_err_i    = 4'b0000;

    // Reset state
    #12;
    chk("rst_req", {28'd0, sbr_req_o}, 32'h0);
    chk("rst_rvalid", {31'd0, mgr_rvalid_o}, 32'h0);
    chk("rst_errcnt", {16'd0, err_cnt_o}, 32'h0);
    @(negedge clk_i) rst_ni = 1'b1;

    // Read 0x1004 to port 2, response with rid 1
    @(negedge clk_i) req(32'h1004, 1'b1);
    #1;
    chk("p2_req", {28'd0, sbr_req_o}, 32'h2);
    chk("p2_gnt", {31'd0, mgr_gnt_o}, 32'h1);
    chk("p2_addr", sbr_addr_o, 32'h1004);
    chk("p2_aid", {31'd0, sbr_aid_o}, 32'h1);
    @(negedge clk_i) mgr_req_i = 1'b0;
    sbr_rvalid_i = 4'b0001;
    #1 chk("p2_ignore_other", {31'd0, mgr_rvalid_o}, 32'h0);
    @(negedge clk_i) sbr_rvalid_i = 4'b0010;
    sbr_rid_i = 4'b0010;
    #1;
    chk("p2_rvalid", {31'd0, mgr_rvalid_o}, 32'h1);
    chk("p2_rdata", mgr_rdata_o, 32'hCAFE0002);
    chk("p2_rid", {31'd0, mgr_rid_o}, 32'h1);
    chk("p2_err", {31'd0, mgr_err_o}, 32'h0);
    @(negedge clk_i) sbr_rvalid_i = 4'b0000;
    sbr_rid_i = 4'b0000;

    // Overlapping rules: lowest rule index wins
    rules_i = rules_b;
    req(32'h80, 1'b0);
    #1 chk("ovl_80", {28'd0, sbr_req_o}, 32'h2);
    mgr_addr_i = 32'h200;
    #1 chk("ovl_200", {28'd0, sbr_req_o}, 32'h1);
    mgr_req_i = 1'b0;
    rules_i = rules_a;

    // Unmatched address goes to the error subordinate
    @(negedge clk_i) req(32'h5000_0000, 1'b1);
    sbr_gnt_i = 4'b0000;
    #1;
    chk("err_gnt", {31'd0, mgr_gnt_o}, 32'h1);
    chk("err_noreq", {28'd0, sbr_req_o}, 32'h0);
    @(negedge clk_i) mgr_req_i = 1'b0;
    #1;
    chk("err_rvalid", {31'd0, mgr_rvalid_o}, 32'h1);
    chk("err_err", {31'd0, mgr_err_o}, 32'h1);
    chk("err_rdata", mgr_rdata_o, 32'hBADCAB1E);
    chk("err_rid", {31'd0, mgr_rid_o}, 32'h1);
    chk("err_cnt1", {16'd0, err_cnt_o}, CntEn ? 32'd1 : 32'd0);
    @(negedge clk_i);
    #1 chk("err_rvalid_done", {31'd0, mgr_rvalid_o}, 32'h0);

    // Bad idx and empty rule, back to back into the error subordinate
    req(32'h3000, 1'b0);
    #1 chk("bad_idx_gnt", {31'd0, mgr_gnt_o}, 32'h1);
    @(negedge clk_i) req(32'h6000, 1'b1);
    #1;
    chk("empty_gnt", {31'd0, mgr_gnt_o}, 32'h1);
    chk("b2b_rvalid0", {31'd0, mgr_rvalid_o}, 32'h1);
    chk("b2b_rid0", {31'd0, mgr_rid_o}, 32'h0);
    @(negedge clk_i) mgr_req_i = 1'b0;
    #1;
    chk("b2b_rvalid1", {31'd0, mgr_rvalid_o}, 32'h1);
    chk("b2b_rid1", {31'd0, mgr_rid_o}, 32'h1);
    chk("err_cnt3", {16'd0, err_cnt_o}, CntEn ? 32'd3 : 32'd0);
    sbr_gnt_i = 4'b1111;

    // MaxTrans: third request to port 1 held until first response
    @(negedge clk_i) req(32'h10, 1'b0);
    @(negedge clk_i) req(32'h20, 1'b0);
    #1 chk("mt_gnt2", {31'd0, mgr_gnt_o}, 32'h1);
    @(negedge clk_i) req(32'h30, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mt_stall_gnt", {31'd0, mgr_gnt_o}, 32'h0);
      chk("mt_stall_req", {28'd0, sbr_req_o}, 32'h0);
      @(negedge clk_i);
    end
    sbr_rvalid_i = 4'b0001;
    #1;
    chk("mt_rvalid", {31'd0, mgr_rvalid_o}, 32'h1);
    chk("mt_still_stalled", {31'd0, mgr_gnt_o}, 32'h0);
    @(negedge clk_i) sbr_rvalid_i = 4'b0000;
    #1;
    chk("mt_gnt3", {31'd0, mgr_gnt_o}, 32'h1);
    chk("mt_req3", {28'd0, sbr_req_o}, 32'h1);
    @(negedge clk_i) mgr_req_i = 1'b0;
    sbr_rvalid_i = 4'b0001;
    @(negedge clk_i);
    @(negedge clk_i) sbr_rvalid_i = 4'b0000;
    #1 chk("mt_drained", {31'd0, mgr_rvalid_o}, 32'h0);

    // Target switch waits for the outstanding response
    @(negedge clk_i) req(32'h10, 1'b0);
    @(negedge clk_i) req(32'h1010, 1'b1);
    #1;
    chk("sw_stall_gnt", {31'd0, mgr_gnt_o}, 32'h0);
    chk("sw_stall_req", {28'd0, sbr_req_o}, 32'h0);
    @(negedge clk_i) sbr_rvalid_i = 4'b0001;
    #1;
    chk("sw_rvalid1", {31'd0, mgr_rvalid_o}, 32'h1);
    chk("sw_rdata1", mgr_rdata_o, 32'hCAFE0001);
    chk("sw_gnt_during_rvalid", {31'd0, mgr_gnt_o}, 32'h0);
    @(negedge clk_i) sbr_rvalid_i = 4'b0000;
    #1;
    chk("sw_gnt", {31'd0, mgr_gnt_o}, 32'h1);
    chk("sw_req", {28'd0, sbr_req_o}, 32'h2);
    @(negedge clk_i) mgr_req_i = 1'b0;
    sbr_rvalid_i = 4'b0010;
    sbr_rid_i = 4'b0010;
    #1;
    chk("sw_rvalid2", {31'd0, mgr_rvalid_o}, 32'h1);
    chk("sw_rdata2", mgr_rdata_o, 32'hCAFE0002);
    @(negedge clk_i) sbr_rvalid_i = 4'b0000;
    sbr_rid_i = 4'b0000;

    // Reset with two outstanding requests
    req(32'h10, 1'b0);
    @(negedge clk_i);
    @(negedge clk_i) mgr_req_i = 1'b0;
    #1 chk("rst_pre_stall", {31'd0, mgr_gnt_o}, 32'h0);
    rst_ni = 1'b0;
    sbr_rvalid_i = 4'b0001;
    #1;
    chk("rst_late_rvalid", {31'd0, mgr_rvalid_o}, 32'h0);
    chk("rst_errcnt_clr", {16'd0, err_cnt_o}, 32'h0);
    req(32'h1010, 1'b0);
    #1 chk("rst_no_stall", {31'd0, mgr_gnt_o}, 32'h1);
    mgr_req_i = 1'b0;
    @(negedge clk_i) rst_ni = 1'b1;
    #1 chk("post_rst_rvalid", {31'd0, mgr_rvalid_o}, 32'h0);
    sbr_rvalid_i = 4'b0000;
    @(negedge clk_i) req(32'h1004, 1'b0);
    #1;
    chk("post_rst_req", {28'd0, sbr_req_o}, 32'h2);
    chk("post_rst_gnt", {31'd0, mgr_gnt_o}, 32'h1);
    @(negedge clk_i) mgr_req_i = 1'b0;
    sbr_rvalid_i = 4'b0010;
    #1;
    chk("post_rst_rvalid2", {31'd0, mgr_rvalid_o}, 32'h1);
    chk("post_rst_rdata", mgr_rdata_o, 32'hCAFE0002);
    @(negedge clk_i) sbr_rvalid_i = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
